// File: rtl/inst_fifo.sv
// Instruction queue between fetch and decode: circular buffer of {instr, pc, adel}
// with flush, and an all-zero (NOP) head whenever the queue is empty.
module inst_fifo #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_adel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instrD,
  output logic [31:0]      pcD,
  output logic             adelD,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

  logic [PTR_W:0]   rp_q, rp_d, wp_q, wp_d, cnt_q, cnt_d;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic             adel_mem  [DEPTH];
  logic             full, empty, push, pop;
  logic [PTR_W-1:0] rd_idx, wr_idx;

  always_comb begin
    full      = (cnt_q == FULL_CNT);
    empty     = (cnt_q == '0);
    // Ready never looks ahead to a same-cycle pop.
    in_ready  = !full && !rst;
    out_valid = !empty;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    rd_idx    = rp_q[PTR_W-1:0];
    wr_idx    = wp_q[PTR_W-1:0];

    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + ONE;
    if (pop)  rp_d = rp_q + ONE;
    if (push && !pop)      cnt_d = cnt_q + ONE;
    else if (pop && !push) cnt_d = cnt_q - ONE;
    if (flush) begin
      rp_d  = '0;
      wp_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_idx] <= in_instr;
      pc_mem[wr_idx]    <= in_pc;
      adel_mem[wr_idx]  <= in_adel;
    end
  end

  always_comb begin
    instrD = empty ? 32'h0 : instr_mem[rd_idx];
    pcD    = empty ? 32'h0 : pc_mem[rd_idx];
    adelD  = empty ? 1'b0  : adel_mem[rd_idx];
    count  = cnt_q;
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model by an independent monitor.
module tb_inst_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_adel = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, adelD;
  logic [31:0] instrD, pcD;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;
  int cycles = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } ent_t;
  ent_t exp_q[$];

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_adel(in_adel),
    .out_valid(out_valid), .out_ready(out_ready),
    .instrD(instrD), .pcD(pcD), .adelD(adelD), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    int n;
    ent_t e;
    n = exp_q.size();
    chk("mon_count", 32'(count), 32'(n));
    chk("mon_out_valid", 32'(out_valid), 32'(n > 0));
    chk("mon_in_ready", 32'(in_ready), 32'((n < DEPTH) && !rst));
    if (n > 0) begin
      chk("mon_instrD", instrD, exp_q[0].instr);
      chk("mon_pcD", pcD, exp_q[0].pc);
      chk("mon_adelD", 32'(adelD), 32'(exp_q[0].adel));
    end else begin
      chk("mon_instrD_empty", instrD, 32'h0);
      chk("mon_pcD_empty", pcD, 32'h0);
      chk("mon_adelD_empty", 32'(adelD), 32'h0);
    end
    if (rst || flush) exp_q.delete();
    else begin
      if (out_ready && n > 0) void'(exp_q.pop_front());
      if (in_valid && n < DEPTH) begin
        e.instr = in_instr; e.pc = in_pc; e.adel = in_adel;
        exp_q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL timeout: got %0d cycles expected below 20000", cycles);
      $fatal(1, "timeout");
    end
  end

  task automatic step(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                      input bit ad, input bit ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_adel = ad;
    in_instr = pc ^ 32'h3C5A_0000;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_instrD", instrD, 0);

    // Basic ordering
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hBFC0_0000 + 32'(4*i), 0, 0);
    chk("basic_count", 32'(count), 3);
    chk("basic_head", pcD, 32'hBFC0_0000);
    for (int i = 0; i < 3; i++) begin
      chk("basic_order", pcD, 32'hBFC0_0000 + 32'(4*i));
      step(0, 0, 0, 0, 0, 1);
    end
    chk("basic_drained_valid", 32'(out_valid), 0);
    chk("basic_drained_instr", instrD, 0);

    // Full
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'h1000 + 32'(4*i), 0, 0);
    chk("full_count", 32'(count), 8);
    chk("full_in_ready", 32'(in_ready), 0);
    step(0, 0, 1, 32'hDEAD_0000, 0, 0);
    chk("full_ninth_rejected", 32'(count), 8);
    step(0, 0, 0, 0, 0, 1);
    chk("full_pop_in_ready", 32'(in_ready), 1);
    chk("full_pop_count", 32'(count), 7);

    // Simultaneous push/pop at count 4
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    chk("sim_start_count", 32'(count), 4);
    pc = 32'h2000;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, pc, 0, 1);
      pc += 4;
      chk("sim_count", 32'(count), 4);
    end

    // Flush priority at count 5
    step(0, 0, 1, 32'h3000, 0, 0);
    chk("flush_pre_count", 32'(count), 5);
    step(0, 1, 1, 32'h3004, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_instr", instrD, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_no_write", 32'(count), 0);

    // Reset mid-operation at count 6
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32'h4000 + 32'(4*i), 0, 0);
    chk("rst_pre_count", 32'(count), 6);
    step(1, 0, 1, 32'h4100, 0, 0);
    chk("rst_in_ready0", 32'(in_ready), 0);
    chk("rst_count0", 32'(count), 0);
    step(1, 0, 1, 32'h4104, 0, 0);
    chk("rst_in_ready1", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 1);
    step(0, 0, 1, 32'h4200, 0, 0);
    chk("rst_first_push_valid", 32'(out_valid), 1);
    chk("rst_first_push_pc", pcD, 32'h4200);

    // Address error passthrough
    step(0, 0, 0, 0, 0, 1);
    rst = 0; flush = 0; in_valid = 1; in_pc = 32'hBFC0_0001; in_adel = 1;
    in_instr = 32'h2402_0001; out_ready = 0;
    @(posedge clk);
    #1;
    chk("adel_flag", 32'(adelD), 1);
    chk("adel_pc", pcD, 32'hBFC0_0001);
    chk("adel_instr", instrD, 32'h2402_0001);
    step(0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(79) == 0, $urandom_range(39) == 0, $urandom_range(2) != 0,
           $urandom, $urandom_range(1), $urandom_range(2) != 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fifo.md
# inst_fifo

Instruction queue between the fetch stage and the main decoder. It accepts fetched instruction words tagged with PC and a fetch address-error flag, and buffers up to DEPTH entries. It presents the oldest entry to decode as `instrD` under a valid/ready handshake. A flush discards all entries on branch mispredict or exception redirect, and the queue drives an all-zero instruction (SLL $0, the NOP encoding) whenever it is empty, so the decoder's control outputs stay inert.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `PTR_W`, $clog2(DEPTH): pointer width; derived, do not override.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `flush`  in  1: discard all entries this edge.
- `in_valid`  in  1: fetch offers an entry.
- `in_ready`  out  1: queue can accept an entry; equals `!full && !rst`.
- `in_instr`  in  32: fetched instruction word.
- `in_pc`  in  32: PC of `in_instr`.
- `in_adel`  in  1: fetch address error for this PC.
- `out_valid`  out  1: head entry present; equals `!empty`.
- `out_ready`  in  1: decode consumes head this cycle.
- `instrD`  out  32: head instruction; 32'h0 when empty.
- `pcD`  out  32: head PC; 32'h0 when empty.
- `adelD`  out  1: head address-error flag; 0 when empty.
- `count`  out  PTR_W+1: number of valid entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries of {instr, pc, adel}, with read pointer `rp`, write pointer `wp` (both PTR_W+1 bits, MSB as wrap bit) and `count`.
- Push: `push = in_valid && in_ready && !flush`. Write the entry at `wp[PTR_W-1:0]`, then `wp <= wp+1`.
- Pop: `pop = out_valid && out_ready && !flush`. Then `rp <= rp+1`.
- Count update: push only gives +1; pop only gives −1; push and pop together leave `count` unchanged.
- Full when `count==DEPTH`, empty when `count==0`. Pointers wrap modulo 2·DEPTH, and the index is the low PTR_W bits.
- No bypass: an entry pushed into an empty queue is visible at the output the next cycle, not the same cycle.
- Full and `out_ready` in the same cycle: `in_ready` is still 0, because ready does not look ahead to a pop. The pop proceeds and `in_ready` rises the next cycle.
- Flush: `rp`, `wp` and `count` go to 0 on that edge. Flush has priority over any push or pop in the same cycle, and neither takes effect. The cycle after a flush, `out_valid`=0 and `instrD`=0.
- Reset: identical to flush. In addition, `in_ready` is held at 0 while `rst` is high.
- Output gating: `instrD`, `pcD` and `adelD` are forced to zero when empty. This guarantees the decoder sees opcode 000000 / funct 000000, which decodes with no memory access, no branch and a write to $0 only.
- Storage array contents are not reset; only pointers and count are reset.
- The queue does not inspect opcodes. Delay-slot pairing is the responsibility of the fetch redirect logic.

## Timing
- Reset values (cycle after `rst` edge, and all later cycles while `rst` stays high): `out_valid`=0, `instrD`=0, `pcD`=0, `adelD`=0, `count`=0. `in_ready` is 0 during `rst` and 1 in the first cycle after `rst` falls.
- Latency: a push at edge N makes the entry visible at the output in cycle N+1.
- Throughput: one push and one pop per cycle sustained whenever `0<count<DEPTH`.
- `in_ready` and `out_valid` are combinational from registered `count` and `rst` only, with no path from `in_valid` or `out_ready`.
- `instrD`, `pcD` and `adelD` are combinational from registered state: array read at `rp` plus empty gating.
- A mid-stream reset or flush takes effect on the same edge. Any handshake asserted in that cycle is dropped, and the producer must re-present the entry after the redirect.

## Test plan
- **Basic ordering:** after reset, push three entries with PCs 0xBFC00000, 0xBFC00004 and 0xBFC00008 on consecutive cycles, with `out_ready`=0.
  - Required: `count`=3 and `pcD`=0xBFC00000.
  - Then raise `out_ready` for 3 cycles. Required: `pcD` sequence 0x…00, 0x…04, 0x…08, then `out_valid`=0 and `instrD`=0.
- **Full:** with DEPTH=8, push 8 entries with `out_ready`=0.
  - Required: `count`=8 and `in_ready`=0. A 9th `in_valid` is not accepted.
  - Next cycle, pop once. Required: `in_ready`=1 the following cycle and `count`=7.
- **Simultaneous push/pop:** at `count`=4, assert push and pop together for 20 cycles with incrementing PCs.
  - Required: `count` stays 4, PCs emerge in order, and both pointers wrap at least twice.
- **Flush priority:** at `count`=5, assert `flush`, `in_valid` and `out_ready` in the same cycle.
  - Required next cycle: `count`=0, `out_valid`=0, `instrD`=0, and no entry was written.
- **Reset mid-operation:** at `count`=6, assert `rst` for 2 cycles while `in_valid`=1.
  - Required: `in_ready`=0 during reset, `count`=0 afterwards, and the first push after reset appears at the output one cycle later.
- **Address error passthrough:** push an entry with `in_pc`=0xBFC00001, `in_adel`=1 and `in_instr`=0x24020001.
  - Required at the head: `adelD`=1, `pcD`=0xBFC00001 and `instrD`=0x24020001.
